// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered 8N1 UART transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_fifo_pkg;

    // Transmit FSM encodings; values are fixed so waveforms read the same across builds
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // 8N1 framing: start + 8 data + stop
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO holding bytes waiting for the transmitter.
// Latency: a pushed word is visible on pop_dat_o and counted from the edge after the push.
// Backpressure: pushes while full and pops while empty are ignored; full_o does not look ahead at a same-cycle pop.
module uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_dat_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             pop_dat_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy tracking; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset since the pointers are cleared
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: queues bytes and sends them as back-to-back 8N1 frames.
// Latency: start bit drives the line one edge after a byte is accepted into an idle, empty block; frame = 10*CLKS_PER_BIT cycles.
// Backpressure: o_Tx_Ready drops when the queue is full; writes while not ready are dropped.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 23,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                              i_Clock,
    input  logic                              i_Rst_L,
    input  logic                              i_Tx_DV,
    input  logic [7:0]                        i_Tx_Byte,
    output logic                              o_Tx_Ready,
    output logic                              o_Tx_Serial,
    output logic                              o_Tx_Active,
    output logic                              o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_Fifo_Count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 serial_q;
    logic                 active_q;
    logic                 done_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [7:0]           fifo_dat;
    logic                 bit_last;
    logic                 done_next;

    assign bit_last  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    // Done is registered, so it is raised one cycle early to land on the final stop-bit cycle
    assign done_next = (state_q == ST_STOP) && (cnt_q == CNT_W'(CLKS_PER_BIT - 2));
    // Byte leaves the queue either when idle or exactly at the stop-bit boundary (no idle gap)
    assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_last));

    uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (i_Clock),
        .rst_n_i    (i_Rst_L),
        .push_i     (i_Tx_DV),
        .push_dat_i (i_Tx_Byte),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (o_Fifo_Count)
    );

    // Frame sequencer: owns bit timing, the shift register and all registered line outputs
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= done_next;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!fifo_empty) begin
                        shift_q   <= fifo_dat;
                        bit_idx_q <= '0;
                        serial_q  <= 1'b0;
                        active_q  <= 1'b1;
                        state_q   <= ST_START;
                    end else begin
                        serial_q <= 1'b1;
                        active_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_last) begin
                        cnt_q    <= '0;
                        serial_q <= shift_q[0];
                        state_q  <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_last) begin
                        cnt_q <= '0;
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                            serial_q <= 1'b1;
                            state_q  <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            serial_q  <= shift_q[bit_idx_q + IDX_W'(1)];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_last) begin
                        cnt_q <= '0;
                        if (!fifo_empty) begin
                            shift_q   <= fifo_dat;
                            bit_idx_q <= '0;
                            serial_q  <= 1'b0;
                            state_q   <= ST_START;
                        end else begin
                            active_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_Tx_Ready  = !fifo_full;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame timing, back-to-back, overflow, reset abort, push/pop overlap, loopback.
// Latency: n/a.
// Backpressure: stimulus honours o_Tx_Ready except where a dropped write is the point of the test.
module tb_uart_tx_fifo;

    localparam int C     = 23;
    localparam int FRAME = 10 * C;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       dv      = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       ready;
    logic       serial;
    logic       active;
    logic       done;
    logic [3:0] count;

    int n_vec = 0;
    int n_err = 0;

    // receiver model state
    logic [7:0] rx_q [$];
    int         rx_cnt = 0;
    int         rx_err = 0;
    logic [7:0] mon_b;
    logic       mon_ok;
    logic       mon_stop;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (8)
    ) dut (
        .i_Clock      (clk),
        .i_Rst_L      (rst_n),
        .i_Tx_DV      (dv),
        .i_Tx_Byte    (tx_byte),
        .o_Tx_Ready   (ready),
        .o_Tx_Serial  (serial),
        .o_Tx_Active  (active),
        .o_Tx_Done    (done),
        .o_Fifo_Count (count)
    );

    // Independent 8N1 receiver: samples mid-bit, discards any frame interrupted by reset
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && serial === 1'b0) begin
                mon_ok = 1'b1;
                repeat (C / 2) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) mon_ok = 1'b0;
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (C) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) mon_ok = 1'b0;
                    end
                    mon_b[i] = serial;
                end
                repeat (C) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) mon_ok = 1'b0;
                end
                mon_stop = serial;
                if (mon_ok) begin
                    if (mon_stop !== 1'b1) rx_err++;
                    rx_q.push_back(mon_b);
                    rx_cnt++;
                end
            end
        end
    end

    // Walks one whole frame cycle by cycle; call it just before the negedge of frame cycle 0
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [9:0] fr;
        logic       exp_done;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            exp_done = (k == FRAME - 1);
            n_vec++;
            if (serial !== fr[k / C]) begin
                n_err++;
                $display("FAIL %s serial cyc %0d: got %b want %b", tag, k, serial, fr[k / C]);
            end
            n_vec++;
            if (active !== 1'b1) begin
                n_err++;
                $display("FAIL %s active cyc %0d: got %b want 1", tag, k, active);
            end
            n_vec++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL %s done cyc %0d: got %b want %b", tag, k, done, exp_done);
            end
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        n_vec++;
        if (serial !== 1'b1) begin n_err++; $display("FAIL %s idle serial: got %b want 1", tag, serial); end
        n_vec++;
        if (active !== 1'b0) begin n_err++; $display("FAIL %s idle active: got %b want 0", tag, active); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL %s idle done: got %b want 0", tag, done); end
        n_vec++;
        if (count !== 4'd0) begin n_err++; $display("FAIL %s idle count: got %0d want 0", tag, count); end
        n_vec++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL %s idle ready: got %b want 1", tag, ready); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dv    = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (serial !== 1'b1) begin n_err++; $display("FAIL reset serial: got %b want 1", serial); end
        n_vec++;
        if (active !== 1'b0) begin n_err++; $display("FAIL reset active: got %b want 0", active); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", done); end
        n_vec++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL reset ready: got %b want 1", ready); end
        n_vec++;
        if (count !== 4'd0) begin n_err++; $display("FAIL reset count: got %0d want 0", count); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        expect_idle("post_reset");
    endtask

    task automatic test_single_byte();
        dv = 1'b1;
        tx_byte = 8'hA5;
        @(posedge clk);
        #1 dv = 1'b0;
        n_vec++;
        if (count !== 4'd1) begin n_err++; $display("FAIL single count_after_push: got %0d want 1", count); end
        @(negedge clk);
        n_vec++;
        if (serial !== 1'b1) begin n_err++; $display("FAIL single pre_frame serial: got %b want 1", serial); end
        expect_frame(8'hA5, "single");
        expect_idle("single");
    endtask

    task automatic test_back_to_back();
        dv = 1'b1;
        tx_byte = 8'h00;
        @(posedge clk);
        #1 tx_byte = 8'hFF;
        fork
            begin
                @(posedge clk);
                #1 tx_byte = 8'h3C;
                @(posedge clk);
                #1 dv = 1'b0;
            end
            begin
                @(negedge clk);
                expect_frame(8'h00, "b2b0");
                expect_frame(8'hFF, "b2b1");
                expect_frame(8'h3C, "b2b2");
            end
        join
        expect_idle("b2b");
    endtask

    task automatic test_overflow();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic exp_r;
                    exp_r = (i < 9);
                    dv = 1'b1;
                    tx_byte = 8'(16 + i);
                    n_vec++;
                    if (ready !== exp_r) begin
                        n_err++;
                        $display("FAIL ovf ready write %0d: got %b want %b", i, ready, exp_r);
                    end
                    if (i == 9) begin
                        n_vec++;
                        if (count !== 4'd8) begin n_err++; $display("FAIL ovf count_full: got %0d want 8", count); end
                    end
                    @(posedge clk);
                    #1;
                end
                dv = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                @(negedge clk);
                for (int i = 0; i < 9; i++) expect_frame(8'(16 + i), "ovf");
            end
        join
        expect_idle("ovf");
        for (int k = 0; k < 3 * C; k++) begin
            @(negedge clk);
            n_vec++;
            if (active !== 1'b0) begin n_err++; $display("FAIL ovf tenth_sent active: got %b want 0", active); end
        end
    endtask

    task automatic test_reset_midframe();
        dv = 1'b1;
        tx_byte = 8'h55;
        @(posedge clk);
        #1 tx_byte = 8'hAA;
        @(posedge clk);
        #1 tx_byte = 8'h0F;
        @(posedge clk);
        #1 dv = 1'b0;
        // now in frame cycle 1; cycle 99 lies inside data bit 3 (cycles 92..114)
        repeat (99) @(negedge clk);
        n_vec++;
        if (serial !== 1'b0) begin n_err++; $display("FAIL rstmid bit3 serial: got %b want 0", serial); end
        n_vec++;
        if (count !== 4'd2) begin n_err++; $display("FAIL rstmid queued: got %0d want 2", count); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (serial !== 1'b1) begin n_err++; $display("FAIL rstmid serial: got %b want 1", serial); end
        n_vec++;
        if (count !== 4'd0) begin n_err++; $display("FAIL rstmid count: got %0d want 0", count); end
        n_vec++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL rstmid ready: got %b want 1", ready); end
        n_vec++;
        if (active !== 1'b0) begin n_err++; $display("FAIL rstmid active: got %b want 0", active); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            n_vec++;
            if (serial !== 1'b1 || active !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid resumed cyc %0d: serial %b active %b want 1 0", k, serial, active);
            end
        end
    endtask

    task automatic test_simul_push_pop();
        dv = 1'b1;
        tx_byte = 8'hC3;
        @(posedge clk);
        #1 tx_byte = 8'h5A;
        fork
            begin
                @(posedge clk);
                #1 dv = 1'b0;
                n_vec++;
                if (count !== 4'd1) begin n_err++; $display("FAIL pushpop idle_pop count: got %0d want 1", count); end
                repeat (229) @(posedge clk);
                #1;
                dv = 1'b1;
                tx_byte = 8'h96;
                n_vec++;
                if (count !== 4'd1) begin n_err++; $display("FAIL pushpop before count: got %0d want 1", count); end
                @(posedge clk);
                #1 dv = 1'b0;
                n_vec++;
                if (count !== 4'd1) begin n_err++; $display("FAIL pushpop after count: got %0d want 1", count); end
            end
            begin
                @(negedge clk);
                expect_frame(8'hC3, "pp0");
                expect_frame(8'h5A, "pp1");
                expect_frame(8'h96, "pp2");
            end
        join
        expect_idle("pushpop");
    endtask

    task automatic test_loopback();
        logic [7:0] exp_q [$];
        logic [7:0] b;
        int         accepted;
        int         base;
        int         t;
        rx_q.delete();
        base     = rx_cnt;
        accepted = 0;
        t        = 0;
        while (accepted < 64 && t < 20000) begin
            if (ready === 1'b1) begin
                b = 8'($urandom);
                dv = 1'b1;
                tx_byte = b;
                exp_q.push_back(b);
                accepted++;
            end else begin
                dv = 1'b0;
            end
            @(posedge clk);
            #1;
            t++;
        end
        dv = 1'b0;
        n_vec++;
        if (accepted != 64) begin n_err++; $display("FAIL loop accepted: got %0d want 64", accepted); end
        t = 0;
        while ((rx_cnt - base) < 64 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        repeat (2 * C) @(negedge clk);
        n_vec++;
        if ((rx_cnt - base) != 64) begin n_err++; $display("FAIL loop rx_dv_count: got %0d want 64", rx_cnt - base); end
        for (int i = 0; i < 64; i++) begin
            n_vec++;
            if (i >= rx_q.size() || i >= exp_q.size()) begin
                n_err++;
                $display("FAIL loop byte %0d: missing (rx %0d exp %0d)", i, rx_q.size(), exp_q.size());
            end else if (rx_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL loop byte %0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (rx_err != 0) begin n_err++; $display("FAIL loop framing errors: got %0d want 0", rx_err); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_simul_push_pop();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
